merge_node_param: RTL and testbench
===================================

// Module: merge_node_param
// PURPOSE
//  Parametrised 2-way streaming merge cell: next-generation building block for the MERGER_TREE_P*_L* family.
//  Merges two sorted, terminator-delimited sequences from FWFT leaf/child FIFOs into one sorted sequence.
//  Generalised in data width, key field, sort direction and counter width.
//  Adds order-violation detection and a completed-sequence counter, which the fixed-width tree cell lacks.
// PARAMETERS
//  DATA_WIDTH  32  width of record on all data ports
//  KEY_WIDTH   32  compared key = data[DATA_WIDTH-1 -: KEY_WIDTH]; KEY_WIDTH <= DATA_WIDTH
//  DESCENDING  1   1: emit largest key first; 0: emit smallest key first
//  CNT_WIDTH   16  width of o_seq_count
// PORTS
//  i_clk             in   1           clock, all state on rising edge
//  i_rst_n           in   1           synchronous reset, active-low
//  i_fifo_a          in   DATA_WIDTH  head of input FIFO A (first-word-fall-through)
//  i_fifo_a_empty    in   1           FIFO A empty
//  o_fifo_a_read     out  1           pop FIFO A this edge
//  i_fifo_b          in   DATA_WIDTH  head of input FIFO B
//  i_fifo_b_empty    in   1           FIFO B empty
//  o_fifo_b_read     out  1           pop FIFO B this edge
//  i_fifo_out_ready  in   1           downstream FIFO accepts a write this cycle
//  o_out_fifo_write  out  1           o_data written downstream this cycle
//  o_data            out  DATA_WIDTH  output record
//  o_seq_count       out  CNT_WIDTH   merged sequences completed, i.e. terminators emitted
//  o_order_err       out  1           sticky: input key out of declared order
// BEHAVIOUR
//  - Terminator: any record whose key == 0. It ends a sequence and sorts after every non-zero key in either mode.
//  - Reset (i_rst_n=0 at edge): state=MERGE; out_valid=0; o_data=0; o_seq_count=0; o_order_err=0; last_key_a/b cleared.
//    Reset overrides any in-flight transfer; no pop is issued in the reset cycle.
//  - Output stage: one register, out_valid.
//    o_out_fifo_write = out_valid & i_fifo_out_ready.
//    load_ok = ~out_valid | i_fifo_out_ready, so a new word may load in the same cycle the old one drains.
//  - Pops: o_fifo_x_read is combinational and asserted only when load_ok and the word is selected.
//    Never asserted while the corresponding empty=1.
//  - Latency: head selected at edge N appears on o_data/o_out_fifo_write from cycle N+1. Throughput is 1 word/cycle.
//  - FSM states: MERGE, DRAIN_A, DRAIN_B.
//    MERGE: requires both FIFOs non-empty, else stall with no pop.
//      both heads terminator -> emit one terminator, pop both, o_seq_count++ (wraps mod 2^CNT_WIDTH), stay MERGE.
//      only B terminator -> emit A, pop A, go DRAIN_A. Only A terminator -> symmetric, go DRAIN_B.
//      neither terminator -> emit the winner and pop it; the winner is the larger key if DESCENDING, else the smaller.
//        Key tie -> A wins.
//    DRAIN_A: B head holds its terminator, which is not popped. Requires only A non-empty.
//      A non-terminator -> emit A, pop A.
//      A terminator -> emit one terminator, pop A and B, o_seq_count++, go MERGE.
//    DRAIN_B: symmetric.
//  - Order check, per side: on each pop of a non-terminator, compare its key with last_key_x.
//    If last_key_x != 0 and the key violates the direction (greater when DESCENDING, smaller otherwise), set o_order_err.
//    On the pop, update last_key_x to the popped key. Popping a terminator clears last_key_x.
//    o_order_err clears only on reset.
//  - Simultaneous stall: if out_valid & ~i_fifo_out_ready, there are no pops and the FSM holds.
//    o_data is held stable while out_valid=1 and not written.
// STRUCTURE
//  - Shared include merger_defs.vh: FSM state localparams (MERGE=2'd0, DRAIN_A=2'd1, DRAIN_B=2'd2) and TERM_KEY=0.
//    The include is reused by future multi-lane tree cells.
//  - One sub-module, merge_key_cmp: combinational, params KEY_WIDTH and DESCENDING.
//    Outputs a_wins, a_term, b_term.
//  - Top level holds the FSM, output register, counters and order checker.
// TESTING
//  1. A={9,5,2,0}, B={8,6,0}, DESCENDING=1, ready=1 -> o_data 9,8,6,5,2,0, one write/cycle after fill, o_seq_count=1, err=0.
//  2. Same data, ready toggling 1,0 every cycle -> identical sequence, no word dropped or duplicated, o_data stable in stall cycles.
//  3. DESCENDING=0, A={1,4,4,0}, B={4,7,0} -> 1,4(A),4(A),4(B),7,0; tie resolved to A.
//  4. B empty for 10 cycles in MERGE with A={3,0} -> zero pops, zero writes. Then B={2,0} -> 3,2,0.
//  5. A={5,7,0} in DESCENDING mode -> o_order_err=1 after 7 popped and stays 1. Reset mid-stream -> all outputs 0, state MERGE.
//  6. Two back-to-back sequence pairs, then CNT_WIDTH=2 with 5 sequence pairs -> o_seq_count reaches 2, wrap case reads 1.

Source files
------------

// File: rtl/merge_node_param_pkg.sv
// Shared definitions for the merge-tree cells: FSM state encoding and the terminator key.
package merge_node_param_pkg;

   typedef enum logic [1:0] {
      MERGE   = 2'd0,
      DRAIN_A = 2'd1,
      DRAIN_B = 2'd2
   } merge_state_e;

   localparam int TERM_KEY = 0;

endpackage

// File: rtl/merge_node_param_key_cmp.sv
// Key comparator for the merge cell: detects terminators and picks the head to emit next.
module merge_key_cmp
   import merge_node_param_pkg::*;
#(
   parameter int KEY_WIDTH  = 32,
   parameter bit DESCENDING = 1'b1
) (
   input  logic [KEY_WIDTH-1:0] key_a_i,
   input  logic [KEY_WIDTH-1:0] key_b_i,
   output logic                 a_wins_o,
   output logic                 a_term_o,
   output logic                 b_term_o
);

   logic a_before_b;

   assign a_term_o = (key_a_i == KEY_WIDTH'(TERM_KEY));
   assign b_term_o = (key_b_i == KEY_WIDTH'(TERM_KEY));

   // Ties go to A in both directions.
   assign a_before_b = DESCENDING ? (key_a_i >= key_b_i) : (key_a_i <= key_b_i);

   // A terminator sorts after every real key, so a lone terminator always loses.
   assign a_wins_o = b_term_o | (~a_term_o & a_before_b);

endmodule

// File: rtl/merge_node_param.sv
// Two-way streaming merge of terminator-delimited sorted sequences from FWFT FIFOs,
// with a one-word output register, completed-sequence counter and sticky order check.
module merge_node_param
   import merge_node_param_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int KEY_WIDTH  = 32,
   parameter bit DESCENDING = 1'b1,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic [DATA_WIDTH-1:0] i_fifo_a,
   input  logic                  i_fifo_a_empty,
   output logic                  o_fifo_a_read,
   input  logic [DATA_WIDTH-1:0] i_fifo_b,
   input  logic                  i_fifo_b_empty,
   output logic                  o_fifo_b_read,
   input  logic                  i_fifo_out_ready,
   output logic                  o_out_fifo_write,
   output logic [DATA_WIDTH-1:0] o_data,
   output logic [CNT_WIDTH-1:0]  o_seq_count,
   output logic                  o_order_err
);

   merge_state_e          state_q, state_d;
   logic                  out_valid_q;
   logic [DATA_WIDTH-1:0] data_q, data_d;
   logic [CNT_WIDTH-1:0]  cnt_q;
   logic                  err_q;
   logic [KEY_WIDTH-1:0]  last_a_q, last_b_q;

   logic [KEY_WIDTH-1:0]  key_a, key_b;
   logic                  a_wins, a_term, b_term;
   logic                  load_ok, emit, pop_a, pop_b, seq_done;
   logic                  viol_a, viol_b;

   assign key_a = i_fifo_a[DATA_WIDTH-1 -: KEY_WIDTH];
   assign key_b = i_fifo_b[DATA_WIDTH-1 -: KEY_WIDTH];

   merge_key_cmp #(
      .KEY_WIDTH  (KEY_WIDTH),
      .DESCENDING (DESCENDING)
   ) u_cmp (
      .key_a_i  (key_a),
      .key_b_i  (key_b),
      .a_wins_o (a_wins),
      .a_term_o (a_term),
      .b_term_o (b_term)
   );

   assign load_ok = ~out_valid_q | i_fifo_out_ready;

   always_comb begin
      state_d  = state_q;
      emit     = 1'b0;
      pop_a    = 1'b0;
      pop_b    = 1'b0;
      seq_done = 1'b0;
      if (load_ok) begin
         case (state_q)
            MERGE: begin
               if (~i_fifo_a_empty & ~i_fifo_b_empty) begin
                  emit = 1'b1;
                  if (a_term & b_term) begin
                     pop_a    = 1'b1;
                     pop_b    = 1'b1;
                     seq_done = 1'b1;
                  end else if (a_wins) begin
                     pop_a = 1'b1;
                     if (b_term) state_d = DRAIN_A;
                  end else begin
                     pop_b = 1'b1;
                     if (a_term) state_d = DRAIN_B;
                  end
               end
            end
            // The idle side's terminator stays at its head until the draining side ends too.
            DRAIN_A: begin
               if (~i_fifo_a_empty) begin
                  if (~a_term) begin
                     emit  = 1'b1;
                     pop_a = 1'b1;
                  end else if (~i_fifo_b_empty) begin
                     emit     = 1'b1;
                     pop_a    = 1'b1;
                     pop_b    = 1'b1;
                     seq_done = 1'b1;
                     state_d  = MERGE;
                  end
               end
            end
            DRAIN_B: begin
               if (~i_fifo_b_empty) begin
                  if (~b_term) begin
                     emit  = 1'b1;
                     pop_b = 1'b1;
                  end else if (~i_fifo_a_empty) begin
                     emit     = 1'b1;
                     pop_a    = 1'b1;
                     pop_b    = 1'b1;
                     seq_done = 1'b1;
                     state_d  = MERGE;
                  end
               end
            end
            default: state_d = MERGE;
         endcase
      end
   end

   assign data_d = (pop_b & ~pop_a) ? i_fifo_b : i_fifo_a;

   assign viol_a = (last_a_q != '0) &&
                   (DESCENDING ? (key_a > last_a_q) : (key_a < last_a_q));
   assign viol_b = (last_b_q != '0) &&
                   (DESCENDING ? (key_b > last_b_q) : (key_b < last_b_q));

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state_q     <= MERGE;
         out_valid_q <= 1'b0;
         data_q      <= '0;
         cnt_q       <= '0;
         err_q       <= 1'b0;
         last_a_q    <= '0;
         last_b_q    <= '0;
      end else begin
         state_q <= state_d;
         if (load_ok) begin
            out_valid_q <= emit;
            if (emit) data_q <= data_d;
         end
         if (seq_done) cnt_q <= cnt_q + CNT_WIDTH'(1);
         if ((pop_a & ~a_term & viol_a) | (pop_b & ~b_term & viol_b)) err_q <= 1'b1;
         if (pop_a) last_a_q <= a_term ? '0 : key_a;
         if (pop_b) last_b_q <= b_term ? '0 : key_b;
      end
   end

   // No pop may escape in a reset cycle, whatever the registered state says.
   assign o_fifo_a_read    = pop_a & i_rst_n;
   assign o_fifo_b_read    = pop_b & i_rst_n;
   assign o_out_fifo_write = out_valid_q & i_fifo_out_ready;
   assign o_data           = data_q;
   assign o_seq_count      = cnt_q;
   assign o_order_err      = err_q;

endmodule

// File: tb/tb_merge_node_param.sv
// Randomised and directed bench for merge_node_param: a descending instance (16-bit key,
// 2-bit counter) and an ascending one (24-bit key), checked against a queue-based merge model.
module tb_merge_node_param;

   logic        clk;
   logic        rst_n;
   logic [31:0] fa, fb;
   logic        ea, eb, rdy;

   logic        rda0, rdb0, wr0, err0;
   logic [31:0] dat0;
   logic [1:0]  cnt0;
   logic        rda1, rdb1, wr1, err1;
   logic [31:0] dat1;
   logic [15:0] cnt1;

   bit          sel;   // 0: descending instance, 1: ascending instance
   logic        rda, rdb, wr, err_m;
   logic [31:0] dat;
   logic [15:0] cnt_m;

   int total = 0;
   int bad   = 0;

   logic [31:0] src_a[$], src_b[$], qa[$], qb[$], got[$], exp_q[$];
   int          exp_cnt;
   bit          exp_err;
   bit          rda_seen, rdb_seen, wr_seen;

   merge_node_param #(
      .DATA_WIDTH(32), .KEY_WIDTH(16), .DESCENDING(1'b1), .CNT_WIDTH(2)
   ) u_desc (
      .i_clk(clk), .i_rst_n(rst_n),
      .i_fifo_a(fa), .i_fifo_a_empty(ea), .o_fifo_a_read(rda0),
      .i_fifo_b(fb), .i_fifo_b_empty(eb), .o_fifo_b_read(rdb0),
      .i_fifo_out_ready(rdy), .o_out_fifo_write(wr0), .o_data(dat0),
      .o_seq_count(cnt0), .o_order_err(err0)
   );

   merge_node_param #(
      .DATA_WIDTH(32), .KEY_WIDTH(24), .DESCENDING(1'b0), .CNT_WIDTH(16)
   ) u_asc (
      .i_clk(clk), .i_rst_n(rst_n),
      .i_fifo_a(fa), .i_fifo_a_empty(ea), .o_fifo_a_read(rda1),
      .i_fifo_b(fb), .i_fifo_b_empty(eb), .o_fifo_b_read(rdb1),
      .i_fifo_out_ready(rdy), .o_out_fifo_write(wr1), .o_data(dat1),
      .o_seq_count(cnt1), .o_order_err(err1)
   );

   always_comb begin
      rda   = sel ? rda1 : rda0;
      rdb   = sel ? rdb1 : rdb0;
      wr    = sel ? wr1  : wr0;
      dat   = sel ? dat1 : dat0;
      err_m = sel ? err1 : err0;
      cnt_m = sel ? cnt1 : {14'd0, cnt0};
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] req);
      total++;
      if (obs !== req) begin
         bad++;
         $display("FAIL %s observed=%0h expected=%0h", tag, obs, req);
      end
   endtask

   function automatic logic [31:0] keyof(input logic [31:0] d);
      return sel ? {8'd0, d[31:8]} : {16'd0, d[31:16]};
   endfunction

   function automatic logic [31:0] rec(input logic [31:0] k, input logic [31:0] p);
      return sel ? {k[23:0], p[7:0]} : {k[15:0], p[15:0]};
   endfunction

   function automatic bit side_err(input logic [31:0] q[$]);
      logic [31:0] last, k;
      bit e;
      last = 0;
      e    = 0;
      foreach (q[i]) begin
         k = keyof(q[i]);
         if (k == 0) last = 0;
         else begin
            if (last != 0 && (sel ? (k < last) : (k > last))) e = 1;
            last = k;
         end
      end
      return e;
   endfunction

   // Plain two-pointer merge of the whole input streams, one terminator per sequence pair.
   task automatic merge_model();
      int ia, ib;
      logic [31:0] ka, kb;
      ia = 0; ib = 0;
      exp_q.delete();
      exp_cnt = 0;
      while (ia < src_a.size() && ib < src_b.size()) begin
         ka = keyof(src_a[ia]);
         kb = keyof(src_b[ib]);
         if (ka == 0 && kb == 0) begin
            exp_q.push_back(src_a[ia]); ia++; ib++; exp_cnt++;
         end else if (kb == 0 || (ka != 0 && (sel ? (ka <= kb) : (ka >= kb)))) begin
            exp_q.push_back(src_a[ia]); ia++;
         end else begin
            exp_q.push_back(src_b[ib]); ib++;
         end
      end
      exp_err = side_err(src_a) | side_err(src_b);
   endtask

   task automatic apply_reset();
      rst_n = 1'b0; ea = 1'b1; eb = 1'b1; rdy = 1'b1; fa = '0; fb = '0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   // One cycle: present heads just after the edge, observe at the falling edge, pop after the next edge.
   task automatic step(input bit r, input bit hold_b);
      ea  = (qa.size() == 0);
      fa  = ea ? 32'h0 : qa[0];
      eb  = hold_b || (qb.size() == 0);
      fb  = (qb.size() == 0) ? 32'h0 : qb[0];
      rdy = r;
      @(negedge clk);
      chk("pop_a_while_empty", {63'd0, rda & ea}, 64'd0);
      chk("pop_b_while_empty", {63'd0, rdb & eb}, 64'd0);
      rda_seen = rda; rdb_seen = rdb; wr_seen = wr;
      if (wr) got.push_back(dat);
      @(posedge clk);
      #1;
      if (rda_seen && qa.size() > 0) void'(qa.pop_front());
      if (rdb_seen && qb.size() > 0) void'(qb.pop_front());
   endtask

   task automatic run(input string tag, input int rmode, input int hold_b, input bit do_rst);
      int cyc, pops_h, wr_h, first_w, last_w;
      bit r;
      logic [31:0] gv;
      merge_model();
      qa = src_a; qb = src_b; got.delete();
      if (do_rst) apply_reset();
      cyc = 0; pops_h = 0; wr_h = 0; first_w = -1; last_w = -1;
      while (got.size() < exp_q.size() && cyc < 3000) begin
         r = (rmode == 0) ? 1'b1 : (rmode == 1) ? (cyc % 2 == 0) : ($urandom_range(0, 1) == 1);
         step(r, cyc < hold_b);
         if (cyc < hold_b) begin
            pops_h += int'(rda_seen | rdb_seen);
            wr_h   += int'(wr_seen);
         end
         if (wr_seen) begin
            if (first_w < 0) first_w = cyc;
            last_w = cyc;
         end
         cyc++;
      end
      chk({tag, "_in_time"}, {63'd0, cyc < 3000}, 64'd1);
      repeat (3) step(1'b1, 1'b0);
      chk({tag, "_words"}, 64'(got.size()), 64'(exp_q.size()));
      foreach (exp_q[i]) begin
         gv = (i < got.size()) ? got[i] : 32'hxxxx_xxxx;
         chk($sformatf("%s_w%0d", tag, i), {32'd0, gv}, {32'd0, exp_q[i]});
      end
      chk({tag, "_seq_count"}, {48'd0, cnt_m}, 64'(sel ? (exp_cnt & 16'hFFFF) : (exp_cnt & 3)));
      chk({tag, "_order_err"}, {63'd0, err_m}, {63'd0, exp_err});
      chk({tag, "_a_left"}, 64'(qa.size()), 64'd0);
      chk({tag, "_b_left"}, 64'(qb.size()), 64'd0);
      if (hold_b > 0) begin
         chk({tag, "_stall_pops"}, 64'(pops_h), 64'd0);
         chk({tag, "_stall_writes"}, 64'(wr_h), 64'd0);
      end
      if (rmode == 0 && hold_b == 0 && exp_q.size() > 0)
         chk({tag, "_rate"}, 64'(last_w - first_w), 64'(exp_q.size() - 1));
      $display("txn %s: mode=%0s words=%0d cycles=%0d count=%0d err=%0d",
               tag, sel ? "asc" : "desc", got.size(), cyc, cnt_m, err_m);
   endtask

   task automatic gen_seq(input bit side, input bit inject_bad);
      int n, k, st;
      logic [31:0] r;
      n = $urandom_range(0, 5);
      k = sel ? $urandom_range(10, 20) : $urandom_range(40, 60);
      for (int i = 0; i < n; i++) begin
         r = rec(32'(k), 32'($urandom_range(0, 255)));
         if (side) src_b.push_back(r); else src_a.push_back(r);
         st = $urandom_range(0, 3);
         if (inject_bad && i == 1) k = sel ? k - 5 : k + 5;
         else                      k = sel ? k + st : k - st;
      end
      if (side) src_b.push_back(32'h0); else src_a.push_back(32'h0);
   endtask

   task automatic gen_pairs(input int pairs, input bit inject_bad);
      src_a.delete(); src_b.delete();
      for (int p = 0; p < pairs; p++) begin
         gen_seq(1'b0, inject_bad && (p == 0));
         gen_seq(1'b1, 1'b0);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      sel = 1'b0; rst_n = 1'b0; ea = 1'b1; eb = 1'b1; rdy = 1'b1; fa = '0; fb = '0;

      // Reset state with full heads on both sides.
      apply_reset();
      rst_n = 1'b0; ea = 1'b0; eb = 1'b0; fa = rec(9, 1); fb = rec(8, 2);
      @(negedge clk);
      chk("rst_no_pop", {62'd0, rda, rdb}, 64'd0);
      @(posedge clk); #1;
      @(negedge clk);
      chk("rst_data", {32'd0, dat}, 64'd0);
      chk("rst_write", {63'd0, wr}, 64'd0);
      chk("rst_count", {48'd0, cnt_m}, 64'd0);
      chk("rst_err", {63'd0, err_m}, 64'd0);

      // Descending basic merge, then the same with ready toggling.
      sel = 1'b0;
      src_a = {rec(9, 1), rec(5, 2), rec(2, 3), 32'h0};
      src_b = {rec(8, 4), rec(6, 5), 32'h0};
      run("desc_basic", 0, 0, 1'b1);
      run("desc_toggle", 1, 0, 1'b1);

      // Ascending with key ties resolved to A (payload distinguishes sides).
      sel = 1'b1;
      src_a = {rec(1, 1), rec(4, 2), rec(4, 3), 32'h0};
      src_b = {rec(4, 9), rec(7, 8), 32'h0};
      run("asc_tie", 0, 0, 1'b1);

      // B held empty for 10 cycles: nothing may move.
      sel = 1'b0;
      src_a = {rec(3, 1), 32'h0};
      src_b = {rec(2, 2), 32'h0};
      run("b_empty_stall", 0, 10, 1'b1);

      // Order violation on A.
      src_a = {rec(5, 1), rec(7, 2), 32'h0};
      src_b = {rec(3, 3), 32'h0};
      run("order_err", 0, 0, 1'b1);

      // Mid-stream reset after an order error, then a fresh merge without another reset.
      src_a = {rec(5, 1), rec(7, 2), rec(9, 3), 32'h0};
      src_b = {rec(1, 4), 32'h0};
      qa = src_a; qb = src_b; got.delete();
      apply_reset();
      step(1'b1, 1'b0);
      step(1'b1, 1'b0);
      step(1'b1, 1'b0);
      chk("mid_err_set", {63'd0, err_m}, 64'd1);
      step(1'b1, 1'b0);
      chk("mid_err_sticky", {63'd0, err_m}, 64'd1);
      rst_n = 1'b0; ea = 1'b0; eb = 1'b0; fa = rec(9, 3); fb = rec(1, 4); rdy = 1'b1;
      @(negedge clk);
      chk("mid_rst_no_pop", {62'd0, rda, rdb}, 64'd0);
      @(posedge clk); #1;
      @(negedge clk);
      chk("mid_rst_data", {32'd0, dat}, 64'd0);
      chk("mid_rst_write", {63'd0, wr}, 64'd0);
      chk("mid_rst_count", {48'd0, cnt_m}, 64'd0);
      chk("mid_rst_err", {63'd0, err_m}, 64'd0);
      @(posedge clk); #1 rst_n = 1'b1;
      src_a = {rec(3, 1), 32'h0};
      src_b = {rec(2, 2), 32'h0};
      run("post_reset_merge", 0, 0, 1'b0);

      // Sequence counting: two pairs ascending, five pairs on the 2-bit counter (wraps to 1).
      sel = 1'b1;
      src_a = {rec(2, 1), 32'h0, rec(5, 2), 32'h0};
      src_b = {rec(3, 3), 32'h0, rec(1, 4), 32'h0};
      run("two_pairs", 0, 0, 1'b1);
      sel = 1'b0;
      gen_pairs(5, 1'b0);
      run("count_wrap", 2, 0, 1'b1);

      // Randomised runs in both directions, some with a planted order violation.
      for (int it = 0; it < 12; it++) begin
         sel = (it % 2) == 1;
         gen_pairs($urandom_range(1, 4), (it % 4) == 3);
         run($sformatf("rand%0d", it), 2, 0, 1'b1);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
